run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- XLEN, 32, data/PC width.
- IMEM_DEPTH, 64, instruction-memory words.
- AW, 6, imem address width; log2(IMEM_DEPTH).
- MAX_CYCLES, 100, run-cycle timeout limit.
- RESULT_REG, 10, architectural register watched (a0).
- PASS_VALUE, 0, result value meaning pass.
- HALT_MODE, 0, halt detection: 0 = first write to RESULT_REG; 1 = PC self-loop.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level sampled per cycle; begins load+run.
- load_valid  in  1  program word valid.
- load_ready  out  1  controller accepts word.
- load_data  in  XLEN  program word.
- load_last  in  1  final word of program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  AW  word address.
- imem_wdata  out  XLEN  write data.
- core_rst  out  1  active-high reset to core.
- wb_we  in  1  core register write enable.
- wb_rd  in  5  core destination register.
- wb_data  in  XLEN  core writeback data.
- pc  in  XLEN  core current PC.
- busy  out  1  state is LOAD or RUN.
- done  out  1  run finished.
- pass  out  1  result equals PASS_VALUE, no timeout.
- timeout  out  1  MAX_CYCLES reached without halt.
- result  out  XLEN  last value written to RESULT_REG.
- cycles  out  32  run cycles elapsed.

Function
REQ-003 FSM states IDLE, LOAD, RUN, DONE; all outputs registered or decoded from state only.
REQ-004 IDLE: core_rst=1, load_ready=0; start=1 -> LOAD, address counter=0.
REQ-005 LOAD: load_ready=1, core_rst=1; each cycle with load_valid: imem_we=1, imem_addr=counter, imem_wdata=load_data (combinational pass-through, same cycle), counter+1.
REQ-006 LOAD exits to RUN on the accepting edge of a word with load_last=1 or at address IMEM_DEPTH-1, whichever first; no write past IMEM_DEPTH-1; load_ready=0 from the next cycle.
REQ-007 Zero-word program impossible: LOAD holds until at least one word accepted; start ignored in LOAD and RUN.
REQ-008 RUN: core_rst=0; cycles increments by 1 every RUN cycle, starting at 0 on the first RUN cycle.
REQ-009 Shadow result: in RUN any wb_we=1 with wb_rd=RESULT_REG loads result<=wb_data; wb_rd=0 never updates result or halts.
REQ-010 HALT_MODE=0: wb_we=1 and wb_rd=RESULT_REG -> DONE next edge; pass=(wb_data==PASS_VALUE).
REQ-011 HALT_MODE=1: pc equal to pc of previous RUN cycle (not checked on first RUN cycle) -> DONE; pass=(result==PASS_VALUE) using result including any same-cycle write.
REQ-012 Timeout: RUN cycle with cycles==MAX_CYCLES-1 and no halt -> DONE, timeout=1, pass=0.
REQ-013 Halt and timeout in same cycle: halt wins, timeout=0.
REQ-014 DONE: core_rst=1, done=1; result, cycles, pass, timeout held; start=1 -> LOAD, clearing done, pass, timeout, result, cycles to 0 on that edge.
REQ-015 busy=1 exactly in LOAD and RUN.
REQ-016 cycles saturates at 2^32-1 (reachable only with oversized MAX_CYCLES).

Reset
REQ-017 rst=0 asynchronously forces IDLE; core_rst=1, done=0, pass=0, timeout=0, result=0, cycles=0, address counter=0, imem_we=0, load_ready=0.
REQ-018 Reset mid-LOAD or mid-RUN aborts immediately; no partial write on the reset cycle; memory contents already written are not cleared.
REQ-019 Deassertion is released synchronously internally; first state change no earlier than the second rising edge after rst rises.

Verification
REQ-020 Load 3 words, last on word 3 -> imem writes at 0,1,2 with correct data; RUN entered the following cycle; core_rst falls.
REQ-021 HALT_MODE=0: core writes x10=0 at run cycle 7 -> done=1, pass=1, result=0, cycles=7, core_rst=1.
REQ-022 HALT_MODE=1, x10=5 written at cycle 4, PC repeats at cycle 9 -> done=1, pass=0, result=5.
REQ-023 MAX_CYCLES=100, no halt -> timeout=1, pass=0, cycles=99; halt on cycle 99 instead -> timeout=0.
REQ-024 64 words without load_last -> write at 63, then RUN; word 65 never accepted (load_ready=0).
REQ-025 rst low during RUN cycle 3 -> IDLE, all outputs at reset values; subsequent start reloads and runs cleanly.

Source files
------------

// File: rtl/run_ctrl.sv
// Test-harness run controller: streams a program into instruction memory, holds the
// core in reset while loading, runs it, and reports halt/timeout with the watched result.
module run_ctrl #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = 6,
  parameter int MAX_CYCLES = 100,
  parameter int RESULT_REG = 10,
  parameter int PASS_VALUE = 0,
  parameter int HALT_MODE  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_last,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_rst,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [XLEN-1:0] result,
  output logic [31:0]     cycles
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e          state_q;
  logic [1:0]      rstSync_q;
  logic            rstInt_n;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] result_d;
  logic [31:0]     cycles_q;
  logic            pass_q;
  logic            timeout_q;
  logic [XLEN-1:0] prevPc_q;
  logic            firstRun_q;
  logic            resultHit;
  logic            selfLoop;
  logic            haltNow;
  logic            lastCycle;
  logic            lastWord;

  // Reset asserts immediately but releases two edges later, clear of the rising rst edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rstSync_q <= 2'b00;
    else      rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstInt_n = rstSync_q[1];

  assign resultHit = wb_we && (wb_rd == 5'(RESULT_REG)) && (wb_rd != 5'd0);
  assign result_d  = resultHit ? wb_data : result_q;
  assign selfLoop  = !firstRun_q && (pc == prevPc_q);
  assign haltNow   = (HALT_MODE == 0) ? resultHit : selfLoop;
  assign lastCycle = (cycles_q == 32'(MAX_CYCLES - 1));
  assign lastWord  = load_last || (addr_q == AW'(IMEM_DEPTH - 1));

  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      result_q   <= '0;
      cycles_q   <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      prevPc_q   <= '0;
      firstRun_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= LOAD;
            addr_q    <= '0;
            result_q  <= '0;
            cycles_q  <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (lastWord) begin
              state_q    <= RUN;
              firstRun_q <= 1'b1;
              cycles_q   <= '0;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        RUN: begin
          prevPc_q   <= pc;
          firstRun_q <= 1'b0;
          if (resultHit) result_q <= wb_data;
          // A halt on the final allowed cycle takes priority over the timeout.
          if (haltNow) begin
            state_q   <= DONE;
            pass_q    <= (result_d == XLEN'(PASS_VALUE));
            timeout_q <= 1'b0;
          end else if (lastCycle) begin
            state_q   <= DONE;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (cycles_q != '1) begin
            cycles_q <= cycles_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == LOAD);
  assign imem_we    = load_ready && load_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = load_data;
  assign core_rst   = (state_q != RUN);
  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign result     = result_q;
  assign cycles     = cycles_q;

endmodule
